// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Receives a byte stream (16-bit LE word count, then 4*N data bytes)
//            and writes the little-endian 32-bit words into the IMEM.
//            Optional macro CHECKSUM_EN adds a trailing XOR checksum byte.
// Revision : 1.0
// ============================================================================
module imem_loader #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [10:0] word_count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN0  = 3'd1;
    localparam logic [2:0] S_LEN1  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;
`ifdef CHECKSUM_EN
    localparam logic [2:0] S_CSUM  = 3'd7;
    localparam logic [2:0] S_TAIL  = S_CSUM;
`else
    localparam logic [2:0] S_TAIL  = S_FIN;
`endif
    localparam logic [16:0] C_DEPTH = 17'(DEPTH_WORDS);

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic [15:0] r_len;
    logic [23:0] r_word;
    logic [1:0]  r_idx;
    logic [31:0] r_wr_addr;
    logic [31:0] r_wr_data;
    logic        r_done;
    logic        r_err;
    logic [10:0] r_word_count;
`ifdef CHECKSUM_EN
    logic [7:0]  r_csum;
`endif
    logic        w_accept;
    logic [15:0] w_len_full;
    logic [15:0] w_count_inc;

    assign w_accept    = byte_valid && byte_ready;
    assign w_len_full  = {byte_data, r_len[7:0]};
    assign w_count_inc = {5'd0, r_word_count} + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_LEN0;
            S_LEN0:  if (w_accept) w_next = S_LEN1;
            S_LEN1: begin
                if (w_accept) begin
                    if (w_len_full == 16'd0)
                        w_next = S_TAIL;
                    else if ({1'b0, w_len_full} > C_DEPTH)
                        w_next = S_ERR;
                    else
                        w_next = S_DATA;
                end
            end
            S_DATA:  if (w_accept && (r_idx == 2'd3)) w_next = S_WRITE;
            S_WRITE: w_next = (w_count_inc == r_len) ? S_TAIL : S_DATA;
`ifdef CHECKSUM_EN
            S_CSUM:  if (w_accept) w_next = (byte_data == r_csum) ? S_FIN : S_ERR;
`endif
            S_FIN:   w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        byte_ready = 1'b0;
        wr_en      = 1'b0;
        busy       = 1'b0;
        case (r_state)
            S_LEN0, S_LEN1, S_DATA: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
            S_WRITE: begin
                wr_en = 1'b1;
                busy  = 1'b1;
            end
`ifdef CHECKSUM_EN
            S_CSUM: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // The write address/data are captured with the 4th byte so they are
    // stable during WRITE and hold afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len        <= 16'd0;
            r_word       <= 24'd0;
            r_idx        <= 2'd0;
            r_wr_addr    <= 32'd0;
            r_wr_data    <= 32'd0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_word_count <= 11'd0;
`ifdef CHECKSUM_EN
            r_csum       <= 8'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_done       <= 1'b0;
                        r_err        <= 1'b0;
                        r_word_count <= 11'd0;
                        r_idx        <= 2'd0;
`ifdef CHECKSUM_EN
                        r_csum       <= 8'd0;
`endif
                    end
                end
                S_LEN0:  if (w_accept) r_len[7:0]  <= byte_data;
                S_LEN1:  if (w_accept) r_len[15:8] <= byte_data;
                S_DATA: begin
                    if (w_accept) begin
                        r_idx <= r_idx + 2'd1;
`ifdef CHECKSUM_EN
                        r_csum <= r_csum ^ byte_data;
`endif
                        case (r_idx)
                            2'd0: r_word[7:0]   <= byte_data;
                            2'd1: r_word[15:8]  <= byte_data;
                            2'd2: r_word[23:16] <= byte_data;
                            default: begin
                                r_wr_data <= {byte_data, r_word};
                                r_wr_addr <= BASE_ADDR + {19'd0, r_word_count, 2'b00};
                            end
                        endcase
                    end
                end
                S_WRITE: r_word_count <= r_word_count + 11'd1;
                S_FIN:   r_done <= 1'b1;
                S_ERR:   r_err  <= 1'b1;
                default: ;
            endcase
        end
    end

    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign done       = r_done;
    assign err        = r_err;
    assign word_count = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Randomized self-checking bench for imem_loader against a
//            stream-level reference model (word list, final flags).
// Revision : 1.0
// ============================================================================
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'd0;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [10:0] word_count;

    imem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state: the word count of the current load and the
    // data bytes that make it up.
    int           cur_n = 0;
    logic [7:0]   dat[$];
    logic [31:0]  obs_addr[$];
    logic [31:0]  obs_data[$];

    // A write is expected exactly one cycle after the last byte of each word.
    int hs_cnt = 0;
    bit exp_wr = 1'b0;
    always @(posedge clk) begin
        if (rst || (start && !busy)) begin
            hs_cnt <= 0;
            exp_wr <= 1'b0;
        end else if (byte_valid && byte_ready) begin
            exp_wr <= (hs_cnt >= 2) && (((hs_cnt - 2) % 4) == 3) && (((hs_cnt - 2) / 4) < cur_n);
            hs_cnt <= hs_cnt + 1;
        end else begin
            exp_wr <= 1'b0;
        end
    end

    always @(negedge clk) begin
        check("wr_en", {31'd0, wr_en}, {31'd0, exp_wr});
        if (wr_en) begin
            obs_addr.push_back(wr_addr);
            obs_data.push_back(wr_data);
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gapmax);
        int g;
        int t;
        g = $urandom_range(gapmax, 0);
        t = 0;
        if (g > 0) begin
            byte_valid = 1'b0;
            repeat (g) @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("ready_timeout", {31'd0, t < 50}, 32'd1);
        @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
        check("rst_wr_en",      {31'd0, wr_en},      32'd0);
        check("rst_wr_addr",    wr_addr,             32'd0);
        check("rst_wr_data",    wr_data,             32'd0);
        check("rst_busy",       {31'd0, busy},       32'd0);
        check("rst_done",       {31'd0, done},       32'd0);
        check("rst_err",        {31'd0, err},        32'd0);
        check("rst_word_count", {21'd0, word_count}, 32'd0);
    endtask

    // One complete load: stream built from n and dat, outcome compared to
    // the model (expected word list, final flags and count).
    task automatic run_load(input int n, input int gapmax, input bit bad_csum,
                            input bit use_dat, input bit mid_start);
        logic [7:0] q[$];
        logic [7:0] cs;
        logic [15:0] nn;
        bit ok;
        int t;
        int exp_words;
        nn = n[15:0];
        cur_n = n;
        obs_addr.delete();
        obs_data.delete();
        if (!use_dat) begin
            dat.delete();
            if (n <= 1024)
                for (int i = 0; i < 4 * n; i++) dat.push_back(8'($urandom));
        end
        q.push_back(nn[7:0]);
        q.push_back(nn[15:8]);
        cs = 8'd0;
        if (n <= 1024) begin
            foreach (dat[i]) begin
                q.push_back(dat[i]);
                cs = cs ^ dat[i];
            end
`ifdef CHECKSUM_EN
            q.push_back(cs ^ {7'd0, bad_csum});
`endif
        end
        pulse_start();
        foreach (q[i]) begin
            if (mid_start && i == 4) start = 1'b1;
            send_byte(q[i], gapmax);
            start = 1'b0;
        end
        byte_valid = 1'b0;
        t = 0;
        while (!(done || err) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("done_timeout", {31'd0, t < 200}, 32'd1);

`ifdef CHECKSUM_EN
        ok = (n <= 1024) && !bad_csum;
`else
        ok = (n <= 1024);
`endif
        exp_words = (n <= 1024) ? n : 0;
        check("done", {31'd0, done}, {31'd0, ok});
        check("err",  {31'd0, err},  {31'd0, !ok});
        check("busy_end", {31'd0, busy}, 32'd0);
        check("word_count", {21'd0, word_count}, 32'(exp_words));
        check("num_writes", 32'(obs_addr.size()), 32'(exp_words));
        for (int i = 0; i < exp_words && i < obs_addr.size(); i++) begin
            check("wr_addr", obs_addr[i], 32'(4 * i));
            check("wr_data", obs_data[i],
                  {dat[4*i+3], dat[4*i+2], dat[4*i+1], dat[4*i]});
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        @(negedge clk);

        // Single word DEADBEEF
        dat = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_load(1, 0, 1'b0, 1'b1, 1'b0);
        check("t1_word", obs_data.size() > 0 ? obs_data[0] : 32'hX, 32'hDEADBEEF);

        // Oversized length, then a fresh start clears err
        run_load(1025, 1, 1'b0, 1'b0, 1'b0);
        pulse_start();
        check("err_cleared", {31'd0, err}, 32'd0);
        check("busy_after_start", {31'd0, busy}, 32'd1);
        run_load(1, 1, 1'b0, 1'b0, 1'b0);

        // Three words with gaps
        run_load(3, 3, 1'b0, 1'b0, 1'b0);

        // Reset after two data bytes
        cur_n = 2;
        obs_addr.delete();
        pulse_start();
        send_byte(8'h02, 1);
        send_byte(8'h00, 1);
        send_byte(8'hA5, 1);
        send_byte(8'h5A, 1);
        byte_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        check("rst_no_write", 32'(obs_addr.size()), 32'd0);
        rst = 1'b0;
        run_load(2, 2, 1'b0, 1'b0, 1'b0);

        // Start pulsed during a load
        run_load(2, 2, 1'b0, 1'b0, 1'b1);

        // Empty load
`ifndef CHECKSUM_EN
        cur_n = 0;
        obs_addr.delete();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        byte_valid = 1'b0;
        check("n0_done_early", {31'd0, done}, 32'd0);
        @(negedge clk);
        check("n0_done", {31'd0, done}, 32'd1);
        check("n0_busy", {31'd0, busy}, 32'd0);
        check("n0_writes", 32'(obs_addr.size()), 32'd0);
`endif
        run_load(0, 1, 1'b0, 1'b0, 1'b0);

`ifdef CHECKSUM_EN
        dat = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_load(1, 0, 1'b0, 1'b1, 1'b0);
        run_load(1, 0, 1'b1, 1'b1, 1'b0);
        check("csum_bad_word", obs_data.size() > 0 ? obs_data[0] : 32'hX, 32'h44332211);
`endif

        // Randomized loads
        for (int k = 0; k < 10; k++) begin
`ifdef CHECKSUM_EN
            run_load($urandom_range(6, 1), $urandom_range(3, 0), 1'($urandom), 1'b0, 1'b0);
`else
            run_load($urandom_range(6, 1), $urandom_range(3, 0), 1'b0, 1'b0, 1'b0);
`endif
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
